// File: rtl/regfile_mp_if.sv
// Register-file bus: two write ports, two read ports, reserve port and busy count.
// The issue/writeback side drives through the master modport; the register file uses slave.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] WriteRegisterA;
    logic [WIDTH-1:0]  WriteDataA;
    logic              RegWriteA;
    logic [ADDR_W-1:0] WriteRegisterB;
    logic [WIDTH-1:0]  WriteDataB;
    logic              RegWriteB;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              ReadBusy1;
    logic              ReadBusy2;
    logic              Reserve;
    logic [ADDR_W-1:0] ReserveRegister;
    logic [CNT_W-1:0]  BusyCount;

    modport master (
        output WriteRegisterA, WriteDataA, RegWriteA,
        output WriteRegisterB, WriteDataB, RegWriteB,
        output ReadRegister1, ReadRegister2,
        output Reserve, ReserveRegister,
        input  ReadData1, ReadData2, ReadBusy1, ReadBusy2, BusyCount
    );

    modport slave (
        input  WriteRegisterA, WriteDataA, RegWriteA,
        input  WriteRegisterB, WriteDataB, RegWriteB,
        input  ReadRegister1, ReadRegister2,
        input  Reserve, ReserveRegister,
        output ReadData1, ReadData2, ReadBusy1, ReadBusy2, BusyCount
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports (B over A), two combinational
// read ports with optional write-through bypass, and a per-register pending-write
// scoreboard with a registered occupancy counter for RAW hazard detection.
// WIDTH/DEPTH must match the connected regfile_mp_if instance.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         Clk,
    input  logic         ResetN,
    regfile_mp_if.slave  rf
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wr_a_ok, wr_b_ok, res_ok;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_data [2];
    logic              rd_busy [2];

    // Addresses beyond DEPTH (non power-of-two depths) and a hardwired r0 are not real storage.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_a_ok = rf.RegWriteA && addr_valid(rf.WriteRegisterA);
    assign wr_b_ok = rf.RegWriteB && addr_valid(rf.WriteRegisterB);
    assign res_ok  = rf.Reserve   && addr_valid(rf.ReserveRegister);

    assign rd_addr[0] = rf.ReadRegister1;
    assign rd_addr[1] = rf.ReadRegister2;

    // Next state: apply A, then B (B overrides on collision), then reserve (wins over a clear).
    always_comb begin
        // NOTE: every variable gets its hold value before any conditional update, so no latch is inferred.
        regs_d = regs_q;
        busy_d = busy_q;
        // NOTE: blocking assignments here so later statements see earlier updates; that ordering is the priority.
        if (wr_a_ok) begin
            regs_d[rf.WriteRegisterA] = rf.WriteDataA;
            busy_d[rf.WriteRegisterA] = 1'b0;
        end
        if (wr_b_ok) begin
            regs_d[rf.WriteRegisterB] = rf.WriteDataB;
            busy_d[rf.WriteRegisterB] = 1'b0;
        end
        if (res_ok) begin
            busy_d[rf.ReserveRegister] = 1'b1;
        end
        // Count follows actual bit transitions, so redundant reserves/clears never skew it.
        count_d = count_q
                + CNT_W'(|(busy_d & ~busy_q))
                - CNT_W'($countones(busy_q & ~busy_d));
    end

    // State registers: storage, busy bits and counter, all cleared asynchronously.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            // NOTE: the storage array is reset on purpose; reads after reset must return zero.
            regs_q  <= '{default: '0};
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Read ports: stored value and busy bit, optionally overridden by this cycle's writes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (addr_valid(rd_addr[p])) begin
                rd_data[p] = regs_q[rd_addr[p]];
                rd_busy[p] = busy_q[rd_addr[p]];
                if (BYPASS) begin
                    if (wr_b_ok && (rf.WriteRegisterB == rd_addr[p])) begin
                        rd_data[p] = rf.WriteDataB;
                        rd_busy[p] = 1'b0;
                    end else if (wr_a_ok && (rf.WriteRegisterA == rd_addr[p])) begin
                        rd_data[p] = rf.WriteDataA;
                        rd_busy[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign rf.ReadData1 = rd_data[0];
    assign rf.ReadData2 = rd_data[1];
    assign rf.ReadBusy1 = rd_busy[0];
    assign rf.ReadBusy2 = rd_busy[1];
    assign rf.BusyCount = count_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (32 regs, r0 hardwired, bypass on / 24 regs,
// r0 writable, bypass off) driven with identical stimulus. A per-instance array model
// predicts outputs into a queue; a negedge monitor pops and compares.
module tb_regfile_mp;
    logic Clk = 1'b0;
    logic ResetN;
    always #5 Clk = ~Clk;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32)) if0 ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(24)) if1 ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut0 (.Clk(Clk), .ResetN(ResetN), .rf(if0.slave));
    regfile_mp #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1'b0), .BYPASS(1'b0))
        dut1 (.Clk(Clk), .ResetN(ResetN), .rf(if1.slave));

    // Shared stimulus
    logic [4:0]  wa, wb, r1, r2, rr;
    logic [31:0] da, db;
    logic        ena, enb, res;

    assign if0.WriteRegisterA = wa;  assign if1.WriteRegisterA = wa;
    assign if0.WriteDataA = da;      assign if1.WriteDataA = da;
    assign if0.RegWriteA = ena;      assign if1.RegWriteA = ena;
    assign if0.WriteRegisterB = wb;  assign if1.WriteRegisterB = wb;
    assign if0.WriteDataB = db;      assign if1.WriteDataB = db;
    assign if0.RegWriteB = enb;      assign if1.RegWriteB = enb;
    assign if0.ReadRegister1 = r1;   assign if1.ReadRegister1 = r1;
    assign if0.ReadRegister2 = r2;   assign if1.ReadRegister2 = r2;
    assign if0.Reserve = res;        assign if1.Reserve = res;
    assign if0.ReserveRegister = rr; assign if1.ReserveRegister = rr;

    // Reference model
    int cfg_depth [2] = '{32, 24};
    bit cfg_zr    [2] = '{1'b1, 1'b0};
    bit cfg_byp   [2] = '{1'b1, 1'b0};
    logic [31:0] mem  [2][32];
    bit          busy [2][32];

    typedef struct {
        int          dut;
        logic [31:0] rd1, rd2;
        bit          rb1, rb2;
        int          cnt;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit valid(input int d, input logic [4:0] a);
        return (int'(a) < cfg_depth[d]) && !(cfg_zr[d] && a == 5'd0);
    endfunction

    function automatic void predict_read(input int d, input logic [4:0] a,
                                         output logic [31:0] data, output bit bz);
        data = 32'd0;
        bz   = 1'b0;
        if (!valid(d, a)) return;
        if (cfg_byp[d] && enb && valid(d, wb) && wb == a) data = db;
        else if (cfg_byp[d] && ena && valid(d, wa) && wa == a) data = da;
        else begin
            data = mem[d][a];
            bz   = busy[d][a];
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) begin
                mem[d][i]  = 32'd0;
                busy[d][i] = 1'b0;
            end
    endfunction

    function automatic void model_edge();
        for (int d = 0; d < 2; d++) begin
            if (ena && valid(d, wa)) begin mem[d][wa] = da; busy[d][wa] = 1'b0; end
            if (enb && valid(d, wb)) begin mem[d][wb] = db; busy[d][wb] = 1'b0; end
            if (res && valid(d, rr)) busy[d][rr] = 1'b1;
        end
    endfunction

    function automatic void push_expect();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.dut = d;
            predict_read(d, r1, e.rd1, e.rb1);
            predict_read(d, r2, e.rd2, e.rb2);
            e.cnt = 0;
            for (int i = 0; i < 32; i++) e.cnt += int'(busy[d][i]);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: compare every queued expectation against live outputs between edges.
    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                check("d0 ReadData1", if0.ReadData1, e.rd1);
                check("d0 ReadData2", if0.ReadData2, e.rd2);
                check("d0 ReadBusy1", {31'd0, if0.ReadBusy1}, {31'd0, e.rb1});
                check("d0 ReadBusy2", {31'd0, if0.ReadBusy2}, {31'd0, e.rb2});
                check("d0 BusyCount", 32'(if0.BusyCount), 32'(e.cnt));
            end else begin
                check("d1 ReadData1", if1.ReadData1, e.rd1);
                check("d1 ReadData2", if1.ReadData2, e.rd2);
                check("d1 ReadBusy1", {31'd0, if1.ReadBusy1}, {31'd0, e.rb1});
                check("d1 ReadBusy2", {31'd0, if1.ReadBusy2}, {31'd0, e.rb2});
                check("d1 BusyCount", 32'(if1.BusyCount), 32'(e.cnt));
            end
        end
    end

    task automatic idle(input logic [4:0] ra = 5'd0, input logic [4:0] rb = 5'd0);
        wa = 5'd0; da = 32'd0; ena = 1'b0;
        wb = 5'd0; db = 32'd0; enb = 1'b0;
        res = 1'b0; rr = 5'd0;
        r1 = ra; r2 = rb;
    endtask

    // One cycle: predict pre-edge outputs, take the edge, advance the model.
    task automatic step();
        push_expect();
        @(posedge Clk);
        if (ResetN) model_edge();
        #1;
    endtask

    initial begin
        ResetN = 1'b0;
        idle();
        model_reset();
        @(posedge Clk);
        #1;
        step();                                   // reset state
        ResetN = 1'b1;

        // Reset mid-operation
        idle(5'd2, 5'd5); ena = 1'b1; wa = 5'd2; da = 32'd42; step();
        idle(5'd2, 5'd5); res = 1'b1; rr = 5'd5; step();
        idle(5'd2, 5'd5); step();
        idle(5'd2, 5'd5); ena = 1'b1; wa = 5'd9; da = 32'h99;
        ResetN = 1'b0; model_reset(); step();      // checked before the next edge
        step();                                    // write pending at reset edge is dropped
        ResetN = 1'b1;
        idle(5'd9, 5'd2); step();

        // Write priority
        idle(5'd3, 5'd3); ena = 1'b1; enb = 1'b1; wa = 5'd3; wb = 5'd3;
        da = 32'h11; db = 32'h22; step();
        idle(5'd3, 5'd3); step();
        idle(5'd4, 5'd6); ena = 1'b1; enb = 1'b1; wa = 5'd4; da = 32'd7; wb = 5'd6; db = 32'd9; step();
        idle(5'd4, 5'd6); step();

        // Bypass vs stored
        idle(5'd2, 5'd2); ena = 1'b1; wa = 5'd2; da = 32'd15; step();
        idle(5'd2, 5'd2); ena = 1'b1; wa = 5'd2; da = 32'd42; step();
        idle(5'd2, 5'd2); step();

        // Zero register
        idle(5'd0, 5'd0); ena = 1'b1; wa = 5'd0; da = 32'd42; res = 1'b1; rr = 5'd0; step();
        idle(5'd0, 5'd0); step();

        // Scoreboard
        idle(5'd7, 5'd7); res = 1'b1; rr = 5'd7; step();
        idle(5'd7, 5'd7); step();
        idle(5'd7, 5'd7); res = 1'b1; rr = 5'd7; ena = 1'b1; wa = 5'd7; da = 32'h77; step();
        idle(5'd7, 5'd7); step();
        idle(5'd7, 5'd7); ena = 1'b1; wa = 5'd7; da = 32'h78; step();
        idle(5'd7, 5'd7); step();

        // Counter fill and double clear with re-reserve
        for (int i = 1; i < 32; i++) begin
            idle(5'(i), 5'd1); res = 1'b1; rr = 5'(i); step();
        end
        idle(5'd1, 5'd2); step();
        idle(5'd1, 5'd2); ena = 1'b1; wa = 5'd1; da = 32'hA1; enb = 1'b1; wb = 5'd2; db = 32'hB2;
        res = 1'b1; rr = 5'd1; step();
        idle(5'd1, 5'd2); step();

        // Out-of-range (only beyond DEPTH for the 24-entry instance)
        idle(5'd30, 5'd30); ena = 1'b1; wa = 5'd30; da = 32'hDEAD; res = 1'b1; rr = 5'd30; step();
        idle(5'd30, 5'd30); step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            wa = 5'($urandom_range(0, 31)); da = $urandom; ena = 1'($urandom_range(0, 1));
            wb = 5'($urandom_range(0, 31)); db = $urandom; enb = 1'($urandom_range(0, 1));
            rr = 5'($urandom_range(0, 31)); res = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wb : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                ResetN = 1'b0; model_reset(); step();
                ResetN = 1'b1;
            end else begin
                step();
            end
        end

        idle();
        step();
        repeat (2) @(posedge Clk);
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the 32x32 two-read/one-write regfile. It provides configurable width and depth, two write ports with fixed priority, and two read ports with optional write-through bypass. It also holds a per-register pending-write scoreboard with an occupancy counter, so the pipeline issue stage can detect RAW hazards. It sits between decode/issue and the writeback stages of the CPU datapath.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers (2..256); ADDR_W = clog2(DEPTH)
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and reserves ignored)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports:
Clk  input  1  clock; all state updates on posedge
ResetN  input  1  asynchronous active-low reset
WriteRegisterA  input  ADDR_W  write port A address
WriteDataA  input  WIDTH  write port A data
RegWriteA  input  1  write port A enable
WriteRegisterB  input  ADDR_W  write port B address (priority port)
WriteDataB  input  WIDTH  write port B data
RegWriteB  input  1  write port B enable
ReadRegister1  input  ADDR_W  read port 1 address
ReadRegister2  input  ADDR_W  read port 2 address
ReadData1  output  WIDTH  read port 1 data (combinational)
ReadData2  output  WIDTH  read port 2 data (combinational)
ReadBusy1  output  1  register at ReadRegister1 has a pending write
ReadBusy2  output  1  register at ReadRegister2 has a pending write
Reserve  input  1  mark ReserveRegister as pending
ReserveRegister  input  ADDR_W  register to reserve
BusyCount  output  clog2(DEPTH+1)  number of pending registers (registered)

Behaviour:
- Reset: ResetN low clears all registers, all busy bits and BusyCount immediately (asynchronous). Release is synchronised externally. A write or reserve pending on the edge on which reset is active is discarded.
- Address validity: an address is "valid" when it is < DEPTH and not (ZERO_REG and == 0).
- Writes: on posedge, each enabled port whose address is valid updates its register. If A and B are both enabled to the same address, B's data is stored.
- Invalid addresses: writes and reserves to invalid addresses are ignored. A read of an invalid address returns 0 with ReadBusy 0.
- Read, BYPASS=0: ReadDataN = stored value. Latency is one edge from write to visibility.
- Read, BYPASS=1: if a valid write this cycle targets ReadRegisterN, ReadDataN = that write's data, with B over A. Otherwise ReadDataN = stored value. This is zero-latency.
- Scoreboard, per register: a busy bit.
  - Reserve with a valid ReserveRegister sets the bit at posedge.
  - Any valid write (A or B) clears the written register's bit at posedge.
  - Reserve and write to the same register on the same edge: reserve wins, the bit ends at 1 (new producer issued).
  - Reserving an already-busy register leaves it at 1.
  - Writing a non-busy register leaves it at 0.
- ReadBusyN = busy[ReadRegisterN]. With BYPASS=1 it is additionally masked to 0 when a valid write this cycle targets ReadRegisterN.
- BusyCount: equals the popcount of the busy bits after each edge; it is a registered counter. Per edge it changes by at most +1 (reserve) and -2 (two distinct writes clearing busy registers).
  - The net delta must be computed from actual bit transitions, never from raw enables.
  - It never exceeds DEPTH - ZERO_REG and never underflows.

Test Plan:
- Reset mid-operation: write 42 to r2, reserve r5, then pulse ResetN low between edges -> ReadData(r2)=0, ReadBusy(r5)=0, BusyCount=0 immediately, without waiting for a clock edge.
- Write priority: RegWriteA=RegWriteB=1, both to r3, A=0x11, B=0x22 -> after the edge r3 reads 0x22. Then A to r4=7 and B to r6=9 on the same edge -> r4=7, r6=9.
- Bypass: BYPASS=1, r2=15 stored, write r2=42 with ReadRegister1=2 before the edge -> ReadData1=42 combinationally, and 42 after the edge. With BYPASS=0 -> 15 before the edge, 42 after.
- Zero register: ZERO_REG=1, write r0=42 and reserve r0 -> ReadData1/2=0, ReadBusy=0, BusyCount unchanged. With ZERO_REG=0, r0 stores 42.
- Scoreboard: reserve r7 -> ReadBusy1(r7)=1, BusyCount=1. Then reserve r7 and write r7 on the same edge -> still busy, count 1. Then write r7 -> busy 0, count 0.
- Counter: reserve r1..r31 over 31 cycles -> BusyCount=31. Then on one edge write r1 (A) and r2 (B) while reserving r1 -> BusyCount=30. Out-of-range address with DEPTH=24: write/reserve r30 ignored, read returns 0.
